// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the VGA timing / test-pattern path.
//   DEF_*   : default 640x480@60 timing (pixels / lines)
//   mode_e  : pattern select encodings
//   clog2   : ceiling log2 used to size the pixel/line counters
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running horizontal/vertical counters and raw timing flags.
//   clk, rst   : pixel clock, synchronous active-high reset
//   hcnt, vcnt : current column / line counters
//   hsync_act  : high while inside the horizontal sync pulse (polarity-free)
//   vsync_act  : high while inside the vertical sync pulse (polarity-free)
//   visible    : current counter position is inside the active area
//   line_end   : hcnt is at its last value (counter wraps on the next edge)
//   frame_end  : last pixel of the last line of the frame
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int X_W      = clog2(H_TOTAL),
  localparam int Y_W      = clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst,
  output logic [X_W-1:0] hcnt,
  output logic [Y_W-1:0] vcnt,
  output logic           hsync_act,
  output logic           vsync_act,
  output logic           visible,
  output logic           line_end,
  output logic           frame_end
);

  localparam logic [X_W-1:0] H_MAX = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_MAX = Y_W'(V_TOTAL - 1);

  // Compare in 32 bits: sync end can equal 2^X_W when the back porch is empty.
  logic [31:0] h32, v32;
  assign h32 = 32'(hcnt);
  assign v32 = 32'(vcnt);

  assign line_end  = (hcnt == H_MAX);
  assign frame_end = line_end && (vcnt == V_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= line_end ? '0 : hcnt + 1'b1;
      if (line_end) vcnt <= (vcnt == V_MAX) ? '0 : vcnt + 1'b1;
    end
  end

  assign hsync_act = (h32 >= 32'(H_VISIBLE + H_FRONT)) &&
                     (h32 <  32'(H_VISIBLE + H_FRONT + H_SYNC));
  assign vsync_act = (v32 >= 32'(V_VISIBLE + V_FRONT)) &&
                     (v32 <  32'(V_VISIBLE + V_FRONT + V_SYNC));
  assign visible   = (h32 < 32'(H_VISIBLE)) && (v32 < 32'(V_VISIBLE));

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing plus registered test-pattern output.
//   clk, rst            : pixel clock, synchronous active-high reset
//   mode                : pattern select (bars/check/ramp/solid), taken at frame end
//   solid_rgb           : {R,G,B} for solid mode, taken at frame end
//   pixelR/G/B          : registered colour, zero outside the active area
//   hsync_out/vsync_out : registered syncs, active level SYNC_POL
//   de                  : output pixel is visible
//   frame_start         : one-cycle pulse with output pixel (0,0)
//   pix_x, pix_y        : position of the output pixel
// All outputs come from one register stage and describe the same pixel.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_BITS = 3,
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit SYNC_POL   = 1'b0,
  parameter int NUM_STRIPS = 8,
  parameter int CHECK_LOG2 = 5,
  localparam int X_W = clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
  localparam int Y_W = clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [3*COLOR_BITS-1:0] solid_rgb,
  output logic [COLOR_BITS-1:0]   pixelR,
  output logic [COLOR_BITS-1:0]   pixelG,
  output logic [COLOR_BITS-1:0]   pixelB,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    de,
  output logic                    frame_start,
  output logic [X_W-1:0]          pix_x,
  output logic [Y_W-1:0]          pix_y
);

  localparam int STRIP_W = H_VISIBLE / NUM_STRIPS;
  // Guard against a zero step when the line is narrower than the level count.
  localparam int RAMP_W  = ((H_VISIBLE >> COLOR_BITS) > 0) ? (H_VISIBLE >> COLOR_BITS) : 1;
  localparam int S_W     = clog2(NUM_STRIPS) + 1;

  localparam logic [X_W-1:0] STRIP_LAST = X_W'(STRIP_W - 1);
  localparam logic [X_W-1:0] RAMP_LAST  = X_W'(RAMP_W - 1);
  localparam logic [S_W-1:0] STRIP_MAX  = S_W'(NUM_STRIPS - 1);

  logic [X_W-1:0] hcnt;
  logic [Y_W-1:0] vcnt;
  logic           hsync_act, vsync_act, visible, line_end, frame_end;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
    .V_VISIBLE (V_VISIBLE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .hsync_act (hsync_act),
    .vsync_act (vsync_act),
    .visible   (visible),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // Mode and solid colour only change across the frame boundary, so a frame
  // is never drawn in two patterns.
  mode_e                   mode_q;
  logic [3*COLOR_BITS-1:0] solid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_BARS;
      solid_q <= '0;
    end else if (frame_end) begin
      mode_q  <= mode_e'(mode);
      solid_q <= solid_rgb;
    end
  end

  // Strip / level counters track hcnt without a divider. They reload on the
  // line wrap, so strip == min(hcnt/STRIP_W, NUM_STRIPS-1) on every line.
  logic [X_W-1:0]        strip_px, ramp_px;
  logic [S_W-1:0]        strip;
  logic [COLOR_BITS-1:0] level;

  always_ff @(posedge clk) begin
    if (rst || line_end) begin
      strip_px <= '0;
      strip    <= '0;
      ramp_px  <= '0;
      level    <= '0;
    end else begin
      if (strip_px == STRIP_LAST) begin
        strip_px <= '0;
        if (strip != STRIP_MAX) strip <= strip + 1'b1;
      end else begin
        strip_px <= strip_px + 1'b1;
      end
      if (ramp_px == RAMP_LAST) begin
        ramp_px <= '0;
        if (level != '1) level <= level + 1'b1;
      end else begin
        ramp_px <= ramp_px + 1'b1;
      end
    end
  end

  logic [COLOR_BITS-1:0] rgb_r, rgb_g, rgb_b;
  logic [2:0]            bar_idx;
  logic                  chk;

  always_comb begin
    rgb_r   = '0;
    rgb_g   = '0;
    rgb_b   = '0;
    bar_idx = 3'(strip);
    chk     = hcnt[CHECK_LOG2] ^ vcnt[CHECK_LOG2];
    if (visible) begin
      case (mode_q)
        MODE_BARS: begin
          // index 0..7 -> white, yellow, cyan, green, magenta, red, blue, black
          rgb_r = {COLOR_BITS{~bar_idx[1]}};
          rgb_g = {COLOR_BITS{~bar_idx[2]}};
          rgb_b = {COLOR_BITS{~bar_idx[0]}};
        end
        MODE_CHECK: {rgb_r, rgb_g, rgb_b} = {(3*COLOR_BITS){~chk}};
        MODE_RAMP: begin
          rgb_r = level;
          rgb_g = level;
          rgb_b = level;
        end
        MODE_SOLID: {rgb_r, rgb_g, rgb_b} = solid_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixelR      <= '0;
      pixelG      <= '0;
      pixelB      <= '0;
      hsync_out   <= ~SYNC_POL;
      vsync_out   <= ~SYNC_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
    end else begin
      pixelR      <= rgb_r;
      pixelG      <= rgb_g;
      pixelB      <= rgb_b;
      hsync_out   <= hsync_act ? SYNC_POL : ~SYNC_POL;
      vsync_out   <= vsync_act ? SYNC_POL : ~SYNC_POL;
      de          <= visible;
      frame_start <= visible && (hcnt == '0) && (vcnt == '0);
      pix_x       <= hcnt;
      pix_y       <= vcnt;
    end
  end

endmodule
